// File: rtl/memory_col_pkg.sv
// Shared constants and types for the single-column word-line memory.
//   MEM_ROWS   : number of rows (width of the one-hot word-line bus)
//   MEM_WIDTH  : bits per row
//   mem_word_t : one row word
package memory_col_pkg;

  localparam int unsigned MEM_ROWS  = 1024;
  localparam int unsigned MEM_WIDTH = 8;

  typedef logic [MEM_WIDTH-1:0] mem_word_t;

endpackage

// File: rtl/memory_row.sv
// One storage row of the column.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, clears the row
//   sel   : word-line select for this row
//   we    : write enable (row loads d when sel && we)
//   d     : write data
//   q     : stored word gated by sel, ready for the bit-line OR
module memory_row #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
    end else if (sel && we) begin
      data <= d;
    end
  end

  assign q = data & {WIDTH{sel}};

endmodule

// File: rtl/memory_col.sv
// Single-column storage array addressed by one-hot (or multi-hot) word lines.
//   clk     : rising-edge clock
//   rst_n   : synchronous active-low reset, clears all rows and rd_data
//   wr_data : write data, loaded into every selected row when byte_en=1
//   byte_en : write enable
//   addr    : word-line select, bit i selects row i
//   rd_data : registered wired-OR of all selected rows (read-first)
module memory_col
  import memory_col_pkg::*;
#(
  parameter int unsigned ROWS  = MEM_ROWS,
  parameter int unsigned WIDTH = MEM_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             byte_en,
  input  logic [ROWS-1:0]  addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] row_q [ROWS];
  logic [WIDTH-1:0] rd_next;

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    memory_row #(
      .WIDTH(WIDTH)
    ) u_row (
      .clk  (clk),
      .rst_n(rst_n),
      .sel  (addr[i]),
      .we   (byte_en),
      .d    (wr_data),
      .q    (row_q[i])
    );
  end

  // Row outputs reflect pre-edge contents, so registering their OR gives
  // read-first behaviour on a same-edge write.
  always_comb begin
    rd_next = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      rd_next = rd_next | row_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_memory_col.sv
module tb_memory_col;
  import memory_col_pkg::*;

  localparam int unsigned ROWS  = MEM_ROWS;
  localparam int unsigned WIDTH = MEM_WIDTH;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] wr_data;
  logic             byte_en;
  logic [ROWS-1:0]  addr;
  logic [WIDTH-1:0] rd_data;

  memory_col #(
    .ROWS (ROWS),
    .WIDTH(WIDTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_data(wr_data),
    .byte_en(byte_en),
    .addr   (addr),
    .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: one entry per clock edge, pushed by the stimulus.
  bit        chk_q[$];
  mem_word_t exp_q[$];
  string     name_q[$];

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model for the random phase.
  mem_word_t mem_m [ROWS];

  // Monitor: after each edge, compare rd_data with the entry for that edge.
  initial begin
    forever begin
      bit        c;
      mem_word_t e;
      string     n;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        c = chk_q.pop_front();
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (c) begin
          tests_run++;
          if (rd_data !== e) begin
            tests_failed++;
            $display("FAIL %s: rd_data=%h expected=%h at %0t", n, rd_data, e, $time);
          end
        end
      end
    end
  end

  function automatic logic [ROWS-1:0] onehot(input int unsigned i);
    logic [ROWS-1:0] a;
    a = '0;
    a[i] = 1'b1;
    return a;
  endfunction

  // Drive one edge's inputs at the negedge, update the model, push expected.
  // use_hand=1 checks against the hand-computed value `hand`, otherwise the model.
  task automatic cyc(input string n, input logic rst, input logic en,
                     input logic [ROWS-1:0] a, input mem_word_t d,
                     input bit chk, input bit use_hand, input mem_word_t hand);
    mem_word_t m;
    @(negedge clk);
    rst_n   = rst;
    byte_en = en;
    addr    = a;
    wr_data = d;
    m = '0;
    if (rst) begin
      for (int unsigned i = 0; i < ROWS; i++) if (a[i]) m = m | mem_m[i];
      if (en) for (int unsigned i = 0; i < ROWS; i++) if (a[i]) mem_m[i] = d;
    end else begin
      for (int unsigned i = 0; i < ROWS; i++) mem_m[i] = '0;
    end
    chk_q.push_back(chk);
    exp_q.push_back(use_hand ? hand : m);
    name_q.push_back(n);
  endtask

  task automatic dir(input string n, input logic rst, input logic en,
                     input logic [ROWS-1:0] a, input mem_word_t d, input mem_word_t hand);
    cyc(n, rst, en, a, d, 1'b1, 1'b1, hand);
  endtask

  initial begin
    #100000;
    tests_failed++;
    $display("FAIL watchdog: time=%0t expected=finish before 100000", $time);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    logic [ROWS-1:0] ra;
    logic [ROWS-1:0] r12;
    int unsigned     pick [8] = '{0, 1, 2, 3, 7, 500, 1022, 1023};

    rst_n = 1'b0; byte_en = 1'b0; addr = '0; wr_data = '0;
    for (int unsigned i = 0; i < ROWS; i++) mem_m[i] = '0;
    r12 = onehot(1) | onehot(2);

    // Reset with random inputs and writes enabled.
    for (int k = 0; k < 2; k++) begin
      for (int unsigned i = 0; i < ROWS; i++) ra[i] = 1'($urandom_range(0, 1));
      dir("reset", 1'b0, 1'b1, ra, mem_word_t'($urandom), 8'h00);
    end
    dir("rst_row0",    1'b1, 1'b0, onehot(0),    8'h00, 8'h00);
    dir("rst_row5",    1'b1, 1'b0, onehot(5),    8'h00, 8'h00);
    dir("rst_row1023", 1'b1, 1'b0, onehot(1023), 8'h00, 8'h00);

    // Single write/read.
    dir("wr_row3",     1'b1, 1'b1, onehot(3), 8'hA5, 8'h00);
    dir("rd_row3",     1'b1, 1'b0, onehot(3), 8'h00, 8'hA5);
    dir("rd_row4",     1'b1, 1'b0, onehot(4), 8'h00, 8'h00);

    // Write disabled.
    dir("wd_row3_a",   1'b1, 1'b0, onehot(3), 8'hFF, 8'hA5);
    dir("wd_row3_b",   1'b1, 1'b0, onehot(3), 8'hFF, 8'hA5);

    // Read-first.
    dir("rf_init",     1'b1, 1'b1, onehot(7), 8'h11, 8'h00);
    dir("rf_old",      1'b1, 1'b1, onehot(7), 8'h22, 8'h11);
    dir("rf_new",      1'b1, 1'b0, onehot(7), 8'h00, 8'h22);

    // Multi-hot write, single reads, OR read.
    dir("mh_wr",       1'b1, 1'b1, r12,       8'h0F, 8'h00);
    dir("mh_rd_row1",  1'b1, 1'b0, onehot(1), 8'h00, 8'h0F);
    dir("mh_rd_row2",  1'b1, 1'b0, onehot(2), 8'h00, 8'h0F);
    dir("mh_wr_row1",  1'b1, 1'b1, onehot(1), 8'h30, 8'h0F);
    dir("mh_wr_row2",  1'b1, 1'b1, onehot(2), 8'h03, 8'h0F);
    dir("mh_or",       1'b1, 1'b0, r12,       8'h00, 8'h33);
    dir("addr_zero",   1'b1, 1'b0, '0,        8'h00, 8'h00);
    dir("zero_wr",     1'b1, 1'b1, '0,        8'hFF, 8'h00);
    dir("zero_wr_chk", 1'b1, 1'b0, r12,       8'h00, 8'h33);

    // Top boundary row.
    dir("wr_row1023",  1'b1, 1'b1, onehot(1023), 8'h5A, 8'h00);
    dir("rd_row1023",  1'b1, 1'b0, onehot(1023), 8'h00, 8'h5A);

    // Reset during a write wins.
    dir("rst_mid_wr",  1'b0, 1'b1, onehot(3), 8'h77, 8'h00);
    dir("rst_row3",    1'b1, 1'b0, onehot(3), 8'h00, 8'h00);
    dir("rst_mh",      1'b1, 1'b0, r12,       8'h00, 8'h00);

    // Random against the model, with occasional reset pulses.
    for (int it = 0; it < 100; it++) begin
      mem_word_t d;
      logic      en;
      int unsigned mode;
      d    = mem_word_t'($urandom);
      en   = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 9);
      if (mode == 0)      ra = '0;
      else if (mode < 3)  ra = onehot(pick[$urandom_range(0, 7)]) | onehot(pick[$urandom_range(0, 7)]);
      else                ra = onehot(pick[$urandom_range(0, 7)]);
      for (int k = 0; k < 3; k++) begin
        cyc("random", !((it % 17 == 9) && (k == 1)), en, ra, d, 1'b1, 1'b0, 8'h00);
      end
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/memory_col.md
# memory_col

Single-column, word-line-addressed storage array: 1024 rows of 8 bits, each row selected by its own line of a one-hot address bus, as a bit-line/word-line memory macro model would use. Writes are byte-granular (one row word per write) under a single write-enable. Reads are continuous and registered. It sits below the memory bank top, which decodes binary addresses into the one-hot word lines.

## Interface
- ROWS, 1024, number of rows; equals the width of `addr`.
- WIDTH, 8, bits per row; equals the width of `wr_data` and `rd_data`.

- clk  in  1  rising-edge clock, sole clock domain
- rst_n  in  1  reset, synchronous, active-low
- wr_data  in  WIDTH  write data
- byte_en  in  1  write enable for the selected row(s); 1 = write
- addr  in  ROWS  word-line select; bit i selects row i
- rd_data  out  WIDTH  registered read data

## Operation
- Storage: ROWS × WIDTH flops, `mem[i]`.
- Write: on a clk edge with rst_n=1 and byte_en=1, every row i with addr[i]=1 loads wr_data. Multi-hot addr writes all selected rows. All-zero addr writes nothing.
- Read: every cycle (independent of byte_en), rd_data is loaded with the bitwise OR of mem[i] over all i with addr[i]=1. This matches wired-OR bit-line behaviour. All-zero addr gives 0.
- Read-during-write is read-first: rd_data gets the row contents from before the same-edge write. New data appears one cycle later if addr is held.
- Reset: on a clk edge with rst_n=0, all mem rows clear to 0 and rd_data clears to 0. Writes and reads are suppressed that cycle. Reset may assert at any cycle, including mid-write. Reset always wins.
- No X propagation is allowed. All state is defined after the first reset edge.

## Timing
- Write latency: data is stored at the edge where byte_en=1 is sampled.
- Read latency: 1 cycle. The addr sampled at edge N produces rd_data valid after edge N.
- Write then read of the same row: rd_data shows the new value after edge N+1 (2 edges after the write is presented).
- rd_data after reset is 0 until the first post-reset edge with a selected non-zero row.
- No handshake. Inputs are sampled every rising edge.

## Structure
- Shared package `memory_col_pkg`:
  - `MEM_ROWS`=1024 and `MEM_WIDTH`=8 constants.
  - typedef `mem_word_t` (logic [MEM_WIDTH-1:0]).
- Sub-module `memory_row`: one WIDTH-bit row.
  - Inputs: clk, rst_n, sel, we, d.
  - Output: q, gated by sel (q & {WIDTH{sel}}).
- The top generates ROWS instances of `memory_row` and ORs the gated outputs into the rd_data register.

## Test plan
- Reset: assert rst_n=0 for 2 cycles with random addr/wr_data/byte_en=1, then read row 0, row 5 and row 1023 → rd_data = 0 for all.
- Single write/read:
  - Write 8'hA5 to addr=1<<3 with byte_en=1.
  - Next cycle byte_en=0 with the same addr → rd_data=8'hA5 one cycle later.
  - addr=1<<4 → rd_data=0.
- Write-disable: byte_en=0 with addr=1<<3 and wr_data=8'hFF → row 3 still reads 8'hA5.
- Read-first: row 7=8'h11; write 8'h22 to row 7 while reading it → rd_data=8'h11 after that edge, then 8'h22 after the next.
- Multi-hot:
  - Write 8'h0F with addr=(1<<1)|(1<<2) → rows 1 and 2 both read 8'h0F.
  - Row 1=8'h30 and row 2=8'h03 read with addr=(1<<1)|(1<<2) → rd_data=8'h33.
  - addr=0 → rd_data=0.
- Random: 100 iterations of random wr_data/byte_en/addr held 3 cycles each, checked against a reference model with the same write/OR-read/read-first rules, including rst_n pulses mid-sequence.
